// File: rtl/brs_pkg.sv
// Shared types for the brs accumulate/FIFO arithmetic unit.
package brs_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  // Per-result status bits; the width-dependent result field is added by the user.
  typedef struct packed {
    logic carry;
    logic sat;
  } flags_t;

endpackage

// File: rtl/brs_sync_fifo.sv
// Single-clock FIFO with async active-high reset, fall-through head and occupancy count.
module brs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/brs_accum_fifo.sv
// Multi-mode ADD/SUB/ACC/CLR unit with optional unsigned saturation,
// feeding a small result FIFO behind valid/ready handshakes.
module brs_accum_fifo
  import brs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_carry,
  output logic                   out_sat,
  output logic [WIDTH-1:0]       acc_value,
  output logic [$clog2(DEPTH):0] fifo_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    flags_t           flags;
  } entry_t;

  localparam int EW = $bits(entry_t);

  op_t              op;
  logic [WIDTH:0]   raw;
  logic             carry;
  logic             accept;
  logic             full, empty;
  logic [WIDTH-1:0] acc_q, acc_d;
  entry_t           entry_d, head;
  logic [EW-1:0]    wr_bits, rd_bits;

  assign op       = op_t'(in_op);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    raw     = '0;
    carry   = 1'b0;
    unique case (op)
      OP_ADD: begin
        raw   = {1'b0, in_a} + {1'b0, in_b};
        carry = raw[WIDTH];
      end
      OP_SUB: begin
        raw   = {1'b0, in_a} - {1'b0, in_b};
        carry = (in_a < in_b);
      end
      OP_ACC: begin
        raw   = {1'b0, acc_q} + {1'b0, in_a};
        carry = raw[WIDTH];
      end
      OP_CLR: begin
        raw   = {1'b0, acc_q};
        carry = 1'b0;
      end
    endcase

    entry_d.result      = raw[WIDTH-1:0];
    entry_d.flags.carry = carry;
    entry_d.flags.sat   = SAT_EN && carry;
    // Overflow clamps high, borrow clamps to zero.
    if (SAT_EN && carry) entry_d.result = (op == OP_SUB) ? '0 : '1;

    acc_d = acc_q;
    if (accept) begin
      if (op == OP_ACC) acc_d = entry_d.result;
      if (op == OP_CLR) acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign wr_bits = entry_d;
  assign head    = rd_bits;

  brs_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_data_i (wr_bits),
    .rd_en_i   (out_ready),
    .rd_data_o (rd_bits),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_count)
  );

  // Head memory is not reset, so mask it while empty.
  assign out_valid  = !empty;
  assign out_result = empty ? '0   : head.result;
  assign out_carry  = empty ? 1'b0 : head.flags.carry;
  assign out_sat    = empty ? 1'b0 : head.flags.sat;
  assign acc_value  = acc_q;

endmodule

// File: tb/tb_brs_accum_fifo.sv
// Table-driven and scoreboard bench for brs_accum_fifo; a second SAT_EN=0 copy runs in lockstep.
module tb_brs_accum_fifo;
  import brs_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         in_ready, out_valid, out_carry, out_sat;
  logic [W-1:0] out_result, acc_value;
  logic [2:0]   fifo_count;
  logic         w_in_ready, w_out_valid, w_out_carry, w_out_sat;
  logic [W-1:0] w_out_result, w_acc_value;
  logic [2:0]   w_fifo_count;

  brs_accum_fifo #(.WIDTH(W), .DEPTH(D), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_sat(out_sat),
    .acc_value(acc_value), .fifo_count(fifo_count)
  );

  brs_accum_fifo #(.WIDTH(W), .DEPTH(D), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_result(w_out_result), .out_carry(w_out_carry), .out_sat(w_out_sat),
    .acc_value(w_acc_value), .fifo_count(w_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rw;
    logic         c;
    logic         s;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] rw,
                              input logic c, input logic s);
    exp_t e;
    e.r = r; e.rw = rw; e.c = c; e.s = s;
    return e;
  endfunction

  function automatic vec_t v(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] r, input logic [W-1:0] rw,
                             input logic c, input logic s);
    vec_t x;
    x.op = op; x.a = a; x.b = b; x.e = mk(r, rw, c, s);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e);
    bit ok;
    ok = 1'b0;
    in_op = op; in_a = a; in_b = b; cur_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("issued op=%0d a=%0d b=%0d exp=%0d/%0d c=%0d s=%0d", op, a, b, e.r, e.rw, e.c, e.s);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      step();
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  // Scoreboard: push on accept, pop/compare on consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", out_result, e.r);
          chk("carry", out_carry, e.c);
          chk("sat", out_sat, e.s);
          chk("wrap_result", w_out_result, e.rw);
          chk("wrap_carry", w_out_carry, e.c);
          chk("wrap_sat", w_out_sat, 0);
          $display("popped result=%0d c=%0d s=%0d wrap=%0d", out_result, out_carry, out_sat,
                   w_out_result);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    vecs[0]  = v(OP_ADD, 200, 100, 255,  44, 1, 1);
    vecs[1]  = v(OP_ADD,  20,  30,  50,  50, 0, 0);
    vecs[2]  = v(OP_SUB,  10,  30,   0, 236, 1, 1);
    vecs[3]  = v(OP_SUB,  30,  10,  20,  20, 0, 0);
    vecs[4]  = v(OP_ADD,   0,   0,   0,   0, 0, 0);
    vecs[5]  = v(OP_ADD, 255,   0, 255, 255, 0, 0);
    vecs[6]  = v(OP_ADD, 255,   1, 255,   0, 1, 1);
    vecs[7]  = v(OP_SUB,   5,   5,   0,   0, 0, 0);
    vecs[8]  = v(OP_ACC, 100,  77, 100, 100, 0, 0);
    vecs[9]  = v(OP_ACC, 100,  77, 200, 200, 0, 0);
    vecs[10] = v(OP_ACC, 100,  77, 255,  44, 1, 1);
    vecs[11] = v(OP_CLR,   9,   9, 255,  44, 0, 0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_acc", acc_value, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, back-to-back with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
    chk("acc_after_clr", acc_value, 0);
    chk("wrap_acc_after_clr", w_acc_value, 0);
    drain();

    // Backpressure: fill to DEPTH, fifth op stalls
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      issue(OP_ADD, W'(k * 10), 1, mk(W'(k * 10 + 1), W'(k * 10 + 1), 0, 0));
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    in_op = OP_ADD; in_a = 50; in_b = 1; cur_exp = mk(51, 51, 0, 0); in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_count", fifo_count, 4);
      chk("stall_head", out_result, 11);
      chk("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("ready_reasserts", ok, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    drain();

    // Concurrent push and pop at count=2 across pointer wrap
    out_ready = 1'b0;
    issue(OP_ADD, 1, 1, mk(2, 2, 0, 0));
    issue(OP_ADD, 2, 2, mk(4, 4, 0, 0));
    chk("conc_start_count", fifo_count, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_op = OP_ADD; in_a = W'(10 + k); in_b = W'(k);
      cur_exp = mk(W'(10 + 2 * k), W'(10 + 2 * k), 0, 0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("conc_count", fifo_count, 2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-stream with three queued entries and a non-zero accumulator
    out_ready = 1'b0;
    issue(OP_ACC, 5, 0, mk(5, 5, 0, 0));
    issue(OP_ACC, 6, 0, mk(11, 11, 0, 0));
    issue(OP_ACC, 7, 0, mk(18, 18, 0, 0));
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_acc", acc_value, 18);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_acc", acc_value, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    issue(OP_ACC, 9, 0, mk(9, 9, 0, 0));
    drain();

    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
